// File: rtl/move_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// move_input_ctrl_if
// Move request handshake between the player-input front end and the game
// core.
//   move_req : a validated move is pending (driven by the front end)
//   move_col : column index of the pending move, stable while move_req=1
//   move_ack : game core has taken the move (driven by the game core)
// Modports: master = input front end, slave = game core.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface move_input_ctrl_if;
    logic       move_req;
    logic [2:0] move_col;
    logic       move_ack;

    modport master (
        output move_req,
        output move_col,
        input  move_ack
    );

    modport slave (
        input  move_req,
        input  move_col,
        output move_ack
    );
endinterface

`default_nettype wire

// File: rtl/move_input_ctrl.sv
// ---------------------------------------------------------------------------
// move_input_ctrl
// Connect-four player input front end. Synchronizes and debounces the select
// button, validates the column switches once per debounced press and hands a
// single move request to the game core over a req/ack handshake. Tracks the
// player to move and the number of accepted moves.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset
//   sw         : raw column switches (one-hot column select)
//   select     : raw, bouncy push button
//   col_full   : per-column full flags
//   game_over  : blocks new moves
//   clear      : synchronous new-game pulse
//   move_if    : move_req / move_col / move_ack handshake (master side)
//   player     : player to move (0 = P1, 1 = P2)
//   reject     : one-cycle pulse for a rejected press
//   move_count : accepted moves, saturating at MAX_MOVES
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module move_input_ctrl #(
    parameter int COLS            = 7,
    parameter int SW_W            = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_MOVES       = 42
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [SW_W-1:0]     sw,
    input  logic                select,
    input  logic [COLS-1:0]     col_full,
    input  logic                game_over,
    input  logic                clear,
    move_input_ctrl_if.master   move_if,
    output logic                player,
    output logic                reject,
    output logic [5:0]          move_count
);

    localparam int             CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [5:0]     MOVES_MAX = 6'(MAX_MOVES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS    = 3'd1,
        S_VALIDATE = 3'd2,
        S_REQ      = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             sel_meta, sel_s;
    logic [2:0]       col_q;
    logic             load_col, accept, reject_nx;

    // Move legality, evaluated combinationally and used only in S_VALIDATE
    logic [COLS-1:0]  cols;
    logic [SW_W-1:0]  upper;
    logic [2:0]       idx;
    logic             one_hot, legal;

    always_comb begin
        cols    = sw[COLS-1:0];
        upper   = sw >> COLS;
        one_hot = (cols != '0) && ((cols & (cols - COLS'(1))) == '0);
        idx     = '0;
        for (int i = 0; i < COLS; i++) begin
            if (cols[i]) idx = 3'(i);
        end
        legal = one_hot && (upper == '0) && !col_full[idx] && !game_over;
    end

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta <= 1'b0;
            sel_s    <= 1'b0;
        end else begin
            sel_meta <= select;
            sel_s    <= sel_meta;
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load_col  = 1'b0;
        accept    = 1'b0;
        reject_nx = 1'b0;
        if (clear) begin
            // Land in RELEASE so a held button cannot re-fire after a new game
            state_nx = S_RELEASE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_s) begin
                        state_nx = S_PRESS;
                        cnt_nx   = '0;
                    end
                end
                S_PRESS: begin
                    if (!sel_s) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else if (cnt_inc == DB_LAST) begin
                        state_nx = S_VALIDATE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                S_VALIDATE: begin
                    if (legal) begin
                        load_col = 1'b1;
                        state_nx = S_REQ;
                    end else begin
                        reject_nx = 1'b1;
                        state_nx  = S_RELEASE;
                        cnt_nx    = '0;
                    end
                end
                S_REQ: begin
                    if (move_if.move_ack) begin
                        accept   = 1'b1;
                        state_nx = S_RELEASE;
                        cnt_nx   = '0;
                    end
                end
                S_RELEASE: begin
                    if (sel_s) begin
                        cnt_nx = '0;
                    end else if (cnt_inc == DB_LAST) begin
                        state_nx = S_IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            player     <= 1'b0;
            reject     <= 1'b0;
            move_count <= '0;
        end else begin
            reject <= reject_nx;
            if (load_col) col_q <= idx;
            if (clear) begin
                player     <= 1'b0;
                move_count <= '0;
            end else if (accept) begin
                player <= ~player;
                if (move_count != MOVES_MAX) move_count <= move_count + 6'd1;
            end
        end
    end

    // Request follows the registered state, so an async reset drops it at once
    assign move_if.move_req = (state == S_REQ);
    assign move_if.move_col = col_q;

endmodule

`default_nettype wire

// File: doc/move_input_ctrl.md
Name: move_input_ctrl

Overview:
- Front end of the connect4 player-input path: converts raw column switches and the `select` button into one clean, validated move request per press.
- Delivers the request to the game core through a req/ack handshake.
- Debounces `select` and rejects illegal moves: not exactly one column, column full, or game over.
- Tracks the player to move and the count of accepted moves.

Parameters:
- COLS, 7, number of board columns; uses `sw[COLS-1:0]`.
- SW_W, 8, switch bus width; `sw[SW_W-1:COLS]` must be 0 for a legal move.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles needed to accept a press or a release.
- MAX_MOVES, 42, saturation value of `move_count`.

Ports:
- clk  in  1  system clock (50 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- sw  in  SW_W  raw column switches, one-hot selects a column.
- select  in  1  raw push-button, asynchronous and bouncy.
- col_full  in  COLS  per-column full flags from the board.
- game_over  in  1  win or draw reached; blocks new moves.
- clear  in  1  synchronous new-game pulse.
- move_ack  in  1  game core has accepted the current request.
- move_req  out  1  a validated move is pending.
- move_col  out  3  column index of the pending move, 0..COLS-1.
- player  out  1  player to move: 0 = P1, 1 = P2.
- reject  out  1  one-cycle pulse when a debounced press is rejected.
- move_count  out  6  number of accepted moves.

Behaviour:
- **Reset** (`reset_n` = 0, async): state = IDLE, `move_req`=0, `move_col`=0, `player`=0, `reject`=0, `move_count`=0, synchronizer flops and debounce counter = 0.
- **Synchronizer:** `select` passes through 2 flops to form `sel_s`. `sw` is sampled only in VALIDATE, with no extra synchronization.
- **FSM states:**
  - **IDLE:** `sel_s`=1 → clear counter, go to PRESS.
  - **PRESS:** counter +1 each cycle `sel_s`=1. A cycle with `sel_s`=0 → IDLE (bounce) with counter cleared. Counter reaches DEBOUNCE_CYCLES → VALIDATE.
  - **VALIDATE** (exactly 1 cycle): the move is legal when all of the following hold:
    - `sw[COLS-1:0]` is exactly one-hot;
    - `sw[SW_W-1:COLS]`=0;
    - `col_full[idx]`=0;
    - `game_over`=0.
  - **VALIDATE outcome:** legal → register `move_col`=idx, go to REQ. Illegal → `reject`=1 for the next cycle only, go to RELEASE.
  - **REQ:** `move_req`=1 and `move_col` held stable; `sw` changes are ignored. On a clock edge with `move_ack`=1:
    - `move_req`→0;
    - `player` toggles;
    - `move_count` +1, saturating at MAX_MOVES;
    - go to RELEASE.
  - **RELEASE:** counter counts consecutive `sel_s`=0 cycles; any `sel_s`=1 clears it. Reaching DEBOUNCE_CYCLES → IDLE. A held button therefore never produces a second move.
- **Latency:** `select` rising before edge E0 → `move_req` high after edge E0+3+DEBOUNCE_CYCLES (E0+7 at default).
- **`move_ack` rules:** ignored outside REQ. May be high on the first REQ cycle, giving a one-cycle request.
- **`clear`** (synchronous; priority over every FSM action):
  - `player`=0, `move_count`=0, `move_req`=0, `reject`=0, counter=0;
  - state → RELEASE, so a pending request is dropped and a held button is not re-fired.
- **`game_over` or `col_full` changing during REQ:** the request stays asserted; the game core owns the final check.
- **Async reset mid-REQ:** `move_req` drops immediately, with no ack required.

Test Plan (DEBOUNCE_CYCLES=4):
- **Clean press:** `sw`=8'b00000010, `select` held 20 cycles → `move_req`=1 after 7 edges, `move_col`=1. Tie `move_ack` high for 1 cycle → `player`=1, `move_count`=1; exactly one request while held.
- **Bounce:** `select` pulses 1 cycle high, 1 low, ×4, then stays high → no `move_req` during the pulses; exactly one request after 4 stable high cycles.
- **Illegal input:**
  - `sw`=8'b00000110 → `reject` pulses 1 cycle, `move_req` stays 0, `player`/`move_count` unchanged.
  - Repeat with `sw`=8'b10000000 → same.
  - Repeat with `sw`=8'b00000100 and `col_full[2]`=1 → same.
  - Repeat with `game_over`=1 → same.
- **Diagonal sequence:** columns 1,2,2,3,3,3,4,4,4,4, each pressed, acked and released → `player` alternates 0,1,0,…; `move_count`=10; `move_col` matches each press.
- **Held ack / late ack:** hold `move_req` 15 cycles with `move_ack`=0 while changing `sw` → `move_col` stable. Ack then raised → single toggle.
- **Clear and reset mid-REQ:**
  - `clear` pulse during REQ → `move_req`=0 next edge, `player`=0, `move_count`=0; no new request until `select` is released for 4 cycles.
  - `reset_n` low asynchronously during REQ → all outputs 0 immediately.
